bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 130 +++++++++++++
 tb/tb_bit_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end. It accepts WIDTH-bit words over a valid/ready
// handshake and sends them MSB-first, one bit per clock, on serial_out.
// A one-entry holding register lets the next word queue behind the word that
// is shifting, so continuous supply streams with no idle gap.
//
// Ports:
//   clock        - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   load_valid   - upstream offers load_data this cycle
//   load_data    - word to serialize; bit WIDTH-1 is sent first
//   load_ready   - block can accept a word this cycle (= !hold_full)
//   serial_out   - registered serial bit; 0 while idle
//   serial_valid - serial_out carries a data bit this cycle
//   word_done    - high while the LSB of a word is on serial_out
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             word_done_q, word_done_d;
    logic             accept;

    // Ready depends only on the holding flag, never on load_valid.
    assign load_ready = !hold_full_q;
    assign accept     = load_valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = load_data;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt_q != '0) begin
                    sreg_d = sreg_q << 1;
                    cnt_d  = cnt_q - CW'(1);
                    if (accept) begin
                        hold_d      = load_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // Last bit on the line: the queued word follows directly.
                    // load_ready is low here, so no accept can collide.
                    sreg_d      = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = CW'(WIDTH - 1);
                end else if (accept) begin
                    // Nothing queued: a word arriving now bypasses hold.
                    sreg_d = load_data;
                    cnt_d  = CW'(WIDTH - 1);
                end else begin
                    sreg_d  = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        serial_valid_d = (state_d == SHIFT);
        serial_out_d   = (state_d == SHIFT) ? sreg_d[WIDTH-1] : 1'b0;
        word_done_d    = (state_d == SHIFT) && (cnt_d == '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            sreg_q         <= '0;
            cnt_q          <= '0;
            hold_q         <= '0;
            hold_full_q    <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            word_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            sreg_q         <= sreg_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            hold_full_q    <= hold_full_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            word_done_q    <= word_done_d;
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign word_done    = word_done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Self-checking bench for bit_serializer (WIDTH = 8). The reference keeps the
// serial line as a queue of pending bits: an accepted word appends its bits
// MSB-first, each clock consumes the bit that was on the line, and the block
// can take a new word whenever no more than one word's worth of bits is
// pending. Directed scenarios plus a randomized run are compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    localparam int W = 8;

    logic         clock;
    logic         reset_n;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         word_done;

    bit_serializer #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .word_done    (word_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_vec  = 0;
    int n_fail = 0;

    // Reference: pending line bits and the matching end-of-word marks.
    bit q_bit[$];
    bit q_last[$];
    bit acc_last = 1'b0;

    // Capture of the valid bits seen on the line for whole-stream checks.
    logic [63:0] cap;
    int          ncap;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit rdy;
        rdy      = (q_bit.size() <= W);
        acc_last = load_valid && rdy;
        if (q_bit.size() > 0) begin
            void'(q_bit.pop_front());
            void'(q_last.pop_front());
        end
        if (acc_last) begin
            for (int i = W - 1; i >= 0; i--) begin
                q_bit.push_back(load_data[i]);
                q_last.push_back(i == 0);
            end
        end
    endtask

    task automatic model_clear();
        q_bit.delete();
        q_last.delete();
        acc_last = 1'b0;
    endtask

    // One clock: advance the model on the rising edge, check on the falling one.
    task automatic tick();
        bit exp_v, exp_o, exp_d, exp_r;
        @(posedge clock);
        if (reset_n) model_edge();
        else acc_last = 1'b0;
        @(negedge clock);
        exp_v = (q_bit.size() > 0);
        exp_o = exp_v ? q_bit[0] : 1'b0;
        exp_d = exp_v ? q_last[0] : 1'b0;
        exp_r = (q_bit.size() <= W);
        check_val("serial_valid", 32'(serial_valid), 32'(exp_v));
        check_val("serial_out",   32'(serial_out),   32'(exp_o));
        check_val("word_done",    32'(word_done),    32'(exp_d));
        check_val("load_ready",   32'(load_ready),   32'(exp_r));
        if (serial_valid) begin
            cap = {cap[62:0], serial_out};
            ncap++;
        end
    endtask

    task automatic idle(input int n);
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Present a word and keep it stable until the reference says it was taken.
    task automatic offer(input logic [W-1:0] w);
        int n;
        load_valid = 1'b1;
        load_data  = w;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_last && n < 64);
        if (!acc_last) check_val("offer_timeout", 32'd0, 32'd1);
        load_valid = 1'b0;
    endtask

    task automatic clear_cap();
        cap  = '0;
        ncap = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_out"},   32'(serial_out),   32'd0);
        check_val({tag, "_valid"}, 32'(serial_valid), 32'd0);
        check_val({tag, "_done"},  32'(word_done),    32'd0);
        check_val({tag, "_ready"}, 32'(load_ready),   32'd1);
    endtask

    initial begin
        load_valid = 1'b0;
        load_data  = '0;
        reset_n    = 1'b1;
        clear_cap();

        // 1. Reset takes effect without any clock edge.
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst0");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_clear();
        idle(1);

        // 2. Single word.
        clear_cap();
        offer(8'b1001_0110);
        idle(10);
        check_val("single_bits",  32'(cap[7:0]), 32'h96);
        check_val("single_count", 32'(ncap),     32'd8);

        // 3. Back-to-back through the holding register.
        clear_cap();
        offer(8'hA5);
        offer(8'h3C);
        idle(18);
        check_val("b2b_bits",  32'(cap[15:0]), 32'hA53C);
        check_val("b2b_count", 32'(ncap),      32'd16);

        // 4. Bypass on the last-bit edge.
        clear_cap();
        offer(8'hFF);
        idle(7);
        offer(8'h00);
        idle(10);
        check_val("bypass_bits",  32'(cap[15:0]), 32'hFF00);
        check_val("bypass_count", 32'(ncap),      32'd16);

        // 5. Stall: third word waits while hold is occupied.
        clear_cap();
        offer(8'h81);
        offer(8'h42);
        offer(8'h24);
        idle(26);
        check_val("stall_bits",  32'(cap[23:0]), 32'h814224);
        check_val("stall_count", 32'(ncap),      32'd24);

        // 6. Reset mid-word with a word held.
        offer(8'hA5);
        offer(8'h3C);
        idle(2);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        model_clear();
        @(negedge clock);
        check_reset_outputs("rst_hold");
        reset_n = 1'b1;
        clear_cap();
        idle(2);
        offer(8'h0F);
        idle(10);
        check_val("post_rst_bits",  32'(cap[7:0]), 32'h0F);
        check_val("post_rst_count", 32'(ncap),     32'd8);

        // Randomized traffic; data stays stable while a word is not taken.
        for (int it = 0; it < 400; it++) begin
            if (!(load_valid && !acc_last)) begin
                load_valid = ($urandom % 4) != 0;
                load_data  = W'($urandom);
            end
            tick();
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
